// File: rtl/ppu_frame_writer_if.sv
// Pixel-stream input and frame-buffer write bus of the PPU frame writer.
// The master modport is the frame writer; the slave modport is the PPU/memory side.
interface ppu_frame_writer_if;
  logic [1:0]  PX_OUT;
  logic        PX_valid;
  logic        FB_WR_REQ;
  logic [13:0] FB_WR_ADDR;
  logic [7:0]  FB_WR_DATA;
  logic        FB_WR_ACK;

  modport master (
    input  PX_OUT, PX_valid, FB_WR_ACK,
    output FB_WR_REQ, FB_WR_ADDR, FB_WR_DATA
  );

  modport slave (
    output PX_OUT, PX_valid, FB_WR_ACK,
    input  FB_WR_REQ, FB_WR_ADDR, FB_WR_DATA
  );
endinterface

// File: rtl/ppu_frame_writer.sv
// PPU frame writer: packs 2-bit pixels 4/byte and streams them through a FIFO into a
// double-buffered 160x144 frame buffer. Define PALETTE_MAP_EN to map pixels through BGP.
module ppu_frame_writer #(
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  ppu_frame_writer_if.master bus,
  input  logic [1:0]         PPU_MODE,
  input  logic [7:0]         LY,
  input  logic               LCD_EN,
  input  logic [7:0]         BGP,
  output logic               FB_RD_BANK,
  output logic               FRAME_DONE,
  output logic               FRAME_ERR,
  output logic               FIFO_OVF
);
  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned OFS_W = 13;
  localparam logic [7:0]  X_LAST = 8'd159;
  localparam logic [7:0]  Y_LAST = 8'd143;
  localparam logic [7:0]  Y_END  = 8'd144;
  localparam logic [1:0]  MODE_VBLANK = 2'd1;
  localparam logic [1:0]  MODE_SCAN   = 2'd2;

  typedef enum logic [1:0] {WAIT_FRAME, ACTIVE, DRAIN} state_t;

  typedef struct packed {
    logic [13:0] addr;
    logic [7:0]  data;
  } wr_entry_t;

  state_t           state_q, state_d;
  logic [7:0]       x_q, y_q;
  logic [7:0]       pack_q;
  logic             wr_bank_q;
  logic             push_q;
  wr_entry_t        push_entry_q;
  wr_entry_t        mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] cnt_q;

  logic             accept_c, abort_c, clear_c, done_c;
  logic             full_c, push_ok_c, pop_c;
  logic [1:0]       px_c;
  logic [7:0]       byte_c;
  logic [OFS_W-1:0] offset_c;

`ifdef PALETTE_MAP_EN
  logic [2:0] pal_idx_c;
  assign pal_idx_c = {bus.PX_OUT, 1'b0};
  assign px_c      = BGP[pal_idx_c +: 2];
`else
  logic unused_bgp;
  assign unused_bgp = ^BGP;
  assign px_c       = bus.PX_OUT;
`endif

  // Byte offset = y*40 + x/4; y stays below 144 while pixels are accepted.
  assign offset_c = OFS_W'({y_q, 5'd0}) + OFS_W'({y_q, 3'd0}) + OFS_W'(x_q[7:2]);

  always_comb begin
    byte_c = pack_q;
    case (x_q[1:0])
      2'd0:    byte_c[7:6] = px_c;
      2'd1:    byte_c[5:4] = px_c;
      2'd2:    byte_c[3:2] = px_c;
      default: byte_c[1:0] = px_c;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= WAIT_FRAME;
    else      state_q <= state_d;
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    if (!LCD_EN) begin
      state_d = WAIT_FRAME;
    end else begin
      case (state_q)
        WAIT_FRAME: if (LY == 8'd0 && PPU_MODE == MODE_SCAN) state_d = ACTIVE;
        ACTIVE: begin
          if (abort_c)                                        state_d = WAIT_FRAME;
          else if (accept_c && x_q == X_LAST && y_q == Y_LAST) state_d = DRAIN;
        end
        DRAIN:   if (done_c) state_d = WAIT_FRAME;
        default: state_d = WAIT_FRAME;
      endcase
    end
  end

  // FSM outputs: per-cycle control strobes
  always_comb begin
    accept_c = 1'b0;
    abort_c  = 1'b0;
    clear_c  = 1'b0;
    done_c   = 1'b0;
    if (!LCD_EN) begin
      clear_c = 1'b1;
    end else begin
      case (state_q)
        ACTIVE: begin
          if (PPU_MODE == MODE_VBLANK && y_q != Y_END) begin
            abort_c = 1'b1;
            clear_c = 1'b1;
          end else if (bus.PX_valid && y_q != Y_END) begin
            accept_c = 1'b1;
          end
        end
        DRAIN:   done_c = (cnt_q == '0) && !bus.FB_WR_REQ && !push_q;
        default: ;
      endcase
    end
  end

  // Pixel counters, packer and completed-byte staging
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      x_q          <= '0;
      y_q          <= '0;
      pack_q       <= '0;
      push_q       <= 1'b0;
      push_entry_q <= '0;
    end else begin
      if (clear_c || done_c) begin
        x_q    <= '0;
        y_q    <= '0;
        pack_q <= '0;
      end else if (accept_c) begin
        pack_q <= byte_c;
        if (x_q == X_LAST) begin
          x_q <= '0;
          y_q <= y_q + 8'd1;
        end else begin
          x_q <= x_q + 8'd1;
        end
      end
      push_q <= accept_c && (x_q[1:0] == 2'd3);
      if (accept_c && x_q[1:0] == 2'd3) begin
        push_entry_q.addr <= {wr_bank_q, offset_c};
        push_entry_q.data <= byte_c;
      end
    end
  end

  // Bank swap and frame status pulses
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_bank_q  <= 1'b0;
      FB_RD_BANK <= 1'b1;
      FRAME_DONE <= 1'b0;
      FRAME_ERR  <= 1'b0;
    end else begin
      FRAME_DONE <= done_c;
      FRAME_ERR  <= abort_c;
      if (done_c) begin
        wr_bank_q  <= ~wr_bank_q;
        FB_RD_BANK <= wr_bank_q;
      end
    end
  end

  // Fullness uses the pre-pop count, so a push into a full FIFO is lost even on a pop cycle.
  assign full_c    = (cnt_q == CNT_W'(FIFO_DEPTH));
  assign push_ok_c = push_q && !full_c;
  assign pop_c     = bus.FB_WR_REQ && bus.FB_WR_ACK;

  always_ff @(posedge clk) begin
    if (push_ok_c) mem[wr_ptr_q] <= push_entry_q;
  end

  // FIFO pointers and the registered write port; the head leaves the FIFO only on transfer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      cnt_q          <= '0;
      FIFO_OVF       <= 1'b0;
      bus.FB_WR_REQ  <= 1'b0;
      bus.FB_WR_ADDR <= '0;
      bus.FB_WR_DATA <= '0;
    end else begin
      if (push_ok_c) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop_c)     rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      cnt_q <= cnt_q + CNT_W'(push_ok_c) - CNT_W'(pop_c);
      if (push_q && full_c) FIFO_OVF <= 1'b1;
      if (pop_c) begin
        bus.FB_WR_REQ <= 1'b0;
      end else if (!bus.FB_WR_REQ && cnt_q != '0) begin
        bus.FB_WR_REQ  <= 1'b1;
        bus.FB_WR_ADDR <= mem[rd_ptr_q].addr;
        bus.FB_WR_DATA <= mem[rd_ptr_q].data;
      end
    end
  end
endmodule

// File: tb/tb_ppu_frame_writer.sv
// Directed bench for ppu_frame_writer: full frames in both banks, packing order,
// aborted frames, FIFO overflow, palette mapping and asynchronous reset.
module tb_ppu_frame_writer;
  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] PPU_MODE;
  logic [7:0] LY;
  logic       LCD_EN;
  logic [7:0] BGP;
  logic       FB_RD_BANK, FRAME_DONE, FRAME_ERR, FIFO_OVF;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int err_cnt = 0;

  typedef struct {
    logic [13:0] a;
    logic [7:0]  d;
  } wr_t;
  wr_t wq[$];

  ppu_frame_writer_if bus();

  ppu_frame_writer #(.FIFO_DEPTH(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .PPU_MODE   (PPU_MODE),
    .LY         (LY),
    .LCD_EN     (LCD_EN),
    .BGP        (BGP),
    .FB_RD_BANK (FB_RD_BANK),
    .FRAME_DONE (FRAME_DONE),
    .FRAME_ERR  (FRAME_ERR),
    .FIFO_OVF   (FIFO_OVF)
  );

  always #5 clk = ~clk;

  // Record every completed write and every status pulse
  always @(negedge clk) begin
    if (rst) begin
      if (bus.FB_WR_REQ && bus.FB_WR_ACK) wq.push_back('{a: bus.FB_WR_ADDR, d: bus.FB_WR_DATA});
      if (FRAME_DONE) done_cnt++;
      if (FRAME_ERR)  err_cnt++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic start_frame();
    @(posedge clk); #1;
    LCD_EN = 1'b1; LY = 8'd0; PPU_MODE = 2'd2; bus.PX_valid = 1'b0;
    @(posedge clk); #1;
    PPU_MODE = 2'd3; LY = 8'd1;
  endtask

  task automatic feed(input int n, input logic [1:0] px);
    bus.PX_OUT = px; bus.PX_valid = 1'b1;
    repeat (n) @(posedge clk);
    #1 bus.PX_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int d0);
    for (int i = 0; i < 400 && done_cnt == d0; i++) @(negedge clk);
    check(tag, done_cnt, d0 + 1);
    tick(1);
  endtask

  task automatic run_frame(input string tag, input logic bank, input logic [1:0] px, input logic [7:0] data);
    int d0, bad;
    logic [13:0] ea;
    wq.delete();
    d0 = done_cnt;
    start_frame();
    feed(23040, px);
    PPU_MODE = 2'd1; LY = 8'd144;
    wait_done({tag, "_done"}, d0);
    bad = 0;
    for (int i = 0; i < wq.size(); i++) begin
      ea = {bank, 13'(i)};
      if (wq[i].a !== ea || wq[i].d !== data) bad++;
    end
    check({tag, "_writes"}, wq.size(), 5760);
    check({tag, "_bad_entries"}, bad, 0);
  endtask

  initial begin
    int d0, e0;
    rst = 1'b0; PPU_MODE = 2'd0; LY = 8'd0; LCD_EN = 1'b0; BGP = 8'hE4;
    bus.PX_OUT = 2'd0; bus.PX_valid = 1'b0; bus.FB_WR_ACK = 1'b1;
    tick(3);
    check("rst_req",     bus.FB_WR_REQ,  1'b0);
    check("rst_addr",    bus.FB_WR_ADDR, 14'd0);
    check("rst_data",    bus.FB_WR_DATA, 8'd0);
    check("rst_rd_bank", FB_RD_BANK,     1'b1);
    check("rst_done",    FRAME_DONE,     1'b0);
    check("rst_err",     FRAME_ERR,      1'b0);
    check("rst_ovf",     FIFO_OVF,       1'b0);
    rst = 1'b1;
    tick(2);

    // Two full frames, one per bank
    run_frame("frame1", 1'b0, 2'b01, 8'h55);
    check("frame1_rd_bank", FB_RD_BANK, 1'b0);
    run_frame("frame2", 1'b1, 2'b10, 8'hAA);
    check("frame2_rd_bank", FB_RD_BANK, 1'b1);
    check("frames_ovf", FIFO_OVF, 1'b0);

    // Pixels 0,1,2,3 at start of line 5, then V_BLANK abort at y==5
    wq.delete();
    d0 = done_cnt; e0 = err_cnt;
    start_frame();
    feed(800, 2'd0);
    feed(1, 2'd0); feed(1, 2'd1); feed(1, 2'd2); feed(1, 2'd3);
    PPU_MODE = 2'd1;
    tick(20);
    check("seq_writes", wq.size(), 201);
    if (wq.size() == 201) begin
      check("seq_addr", wq[200].a, 14'd200);
      check("seq_data", wq[200].d, 8'h1B);
    end
    check("abort_err_pulse", err_cnt, e0 + 1);
    check("abort_no_done",   done_cnt, d0);
    check("abort_rd_bank",   FB_RD_BANK, 1'b1);

    // Next frame restarts in the same bank at offset 0; LCD off ends it silently
    wq.delete();
    start_frame();
    feed(8, 2'd3);
    tick(10);
    check("restart_writes", wq.size(), 2);
    if (wq.size() == 2) begin
      check("restart_addr0", wq[0].a, 14'd0);
      check("restart_addr1", wq[1].a, 14'd1);
    end
    LCD_EN = 1'b0;
    tick(5);
    check("lcd_off_no_err",  err_cnt, e0 + 1);
    check("lcd_off_no_done", done_cnt, d0);

    // Overflow with ACK held low: 8 entries fit, the 9th byte is dropped
    wq.delete();
    bus.FB_WR_ACK = 1'b0;
    start_frame();
    feed(33, 2'd3);
    tick(2);
    check("ovf_after_8", FIFO_OVF, 1'b0);
    check("stall_req",   bus.FB_WR_REQ, 1'b1);
    feed(3, 2'd3);
    tick(2);
    check("ovf_after_9", FIFO_OVF, 1'b1);
    feed(124, 2'd3);
    tick(2);
    check("stall_req_end",  bus.FB_WR_REQ,  1'b1);
    check("stall_addr_end", bus.FB_WR_ADDR, 14'd0);
    check("stall_data_end", bus.FB_WR_DATA, 8'hFF);
    check("stall_no_xfer",  wq.size(), 0);
    LCD_EN = 1'b0;
    bus.FB_WR_ACK = 1'b1;
    tick(30);
    check("ovf_drained", wq.size(), 8);
    if (wq.size() == 8) check("ovf_last_addr", wq[7].a, 14'd7);
    check("ovf_sticky", FIFO_OVF, 1'b1);

    // Palette mapping of PX_OUT=3 with two BGP values
    wq.delete();
    start_frame();
    BGP = 8'hE4; feed(4, 2'd3);
    BGP = 8'h1B; feed(4, 2'd3);
    tick(10);
    check("pal_writes", wq.size(), 2);
    if (wq.size() == 2) begin
      check("pal_byte0", wq[0].d, 8'hFF);
`ifdef PALETTE_MAP_EN
      check("pal_byte1", wq[1].d, 8'h00);
`else
      check("pal_byte1", wq[1].d, 8'hFF);
`endif
    end

    // Asynchronous reset with a write request in flight
    LCD_EN = 1'b0;
    tick(2);
    bus.FB_WR_ACK = 1'b0;
    start_frame();
    feed(4, 2'd1);
    tick(3);
    check("pre_rst_req", bus.FB_WR_REQ, 1'b1);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("async_rst_req",     bus.FB_WR_REQ,  1'b0);
    check("async_rst_addr",    bus.FB_WR_ADDR, 14'd0);
    check("async_rst_data",    bus.FB_WR_DATA, 8'd0);
    check("async_rst_ovf",     FIFO_OVF,       1'b0);
    check("async_rst_rd_bank", FB_RD_BANK,     1'b1);
    tick(2);
    rst = 1'b1;
    tick(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
